w4a8_result_drain: RTL and testbench
====================================

W4A8_RESULT_DRAIN -- requirements
Module: w4a8_result_drain

Interface
REQ-001 SHALL have parameter M, default 8, meaning rows per result tile.
REQ-002 SHALL have parameter N, default 8, meaning columns per result tile.
REQ-003 SHALL have parameter RESULT_WIDTH, default 32, meaning signed accumulator width per element.
REQ-004 SHALL have parameter SCALE_WIDTH, default 16, meaning signed per-column scale width.
REQ-005 SHALL have parameter OUT_WIDTH, default 8, meaning signed requantized element width.
REQ-006 SHALL have port clk, input, 1, meaning clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-008 SHALL have port tile_valid_i, input, 1, meaning a single-cycle tile-done strobe from the GEMM core; there is no backpressure to the core.
REQ-009 SHALL have port tile_i, input, M*N*RESULT_WIDTH, meaning row-major result tile; element (i,j) is at bits [(i*N+j)*RESULT_WIDTH +: RESULT_WIDTH].
REQ-010 SHALL have port scale_i, input, N*SCALE_WIDTH, meaning per-column scale, sampled together with the tile.
REQ-011 SHALL have port shift_i, input, 6, meaning right-shift amount, static while busy_o=1.
REQ-012 SHALL have port m_valid, output, 1, meaning an output row is valid.
REQ-013 SHALL have port m_ready, input, 1, meaning the downstream accepts; transfer occurs when m_valid and m_ready are both 1.
REQ-014 SHALL have port m_data, output, N*OUT_WIDTH, meaning one requantized row; column j is at [j*OUT_WIDTH +: OUT_WIDTH].
REQ-015 SHALL have port m_row, output, clog2(M), meaning the row index of m_data.
REQ-016 SHALL have port m_last, output, 1, meaning m_row equals M-1.
REQ-017 SHALL have port overflow_o, output, 1, meaning sticky flag for a dropped tile.
REQ-018 SHALL have port busy_o, output, 1, meaning a tile is buffered or an output row is pending.

Function
REQ-019 SHALL hold two tile slots (ping-pong), each storing tile and scale, with a write pointer, a read pointer and an occupancy count of 0..2.
REQ-020 SHALL, on tile_valid_i, write the slot at the write pointer and toggle the write pointer, provided count<2 or a slot is freed in the same cycle.
REQ-021 SHALL, on tile_valid_i with count==2 and no slot freed that cycle, drop the tile, leave both slots and pointers unchanged, and set overflow_o to 1 until rst.
REQ-022 SHALL load the output register when count>0 and (m_valid==0 or m_ready==1): row = row counter of the read slot; row counter then increments.
REQ-023 SHALL, when row M-1 of a slot is loaded into the output register, free that slot: toggle the read pointer, reset the row counter to 0, decrement count; a simultaneous write makes count net unchanged.
REQ-024 SHALL compute each element as p = acc*scale[j], a signed full-width product (RESULT_WIDTH+SCALE_WIDTH bits).
REQ-025 SHALL round as r = (p + 2^(shift_i-1)) >>> shift_i (arithmetic shift) when shift_i>0, and r = p when shift_i==0.
REQ-026 SHALL saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-027 SHALL hold m_data, m_row and m_last stable while m_valid=1 and m_ready=0.
REQ-028 SHALL have latency such that a tile strobed in cycle c into an idle block yields m_valid=1 with row 0 in cycle c+2; at full throughput this is one row per cycle with no bubbles across tile boundaries.
REQ-029 SHALL emit rows in order 0..M-1 per tile, and tiles in arrival order.
REQ-030 SHALL drive busy_o = (count!=0) or m_valid.

Reset
REQ-031 SHALL, while rst=1, clear count, both pointers, the row counter, m_valid, m_data, m_row, m_last and overflow_o to 0, and ignore tile_valid_i.
REQ-032 SHALL discard buffered and pending rows on rst mid-drain; the first row after reset comes only from a new tile.

Verification
REQ-033 SHALL be covered: one tile with all acc=100, scale=5, shift=3, m_ready=1 -> 8 rows of all 63, cycles c+2..c+9, m_last only on row 7.
REQ-034 SHALL be covered: acc=-100, scale=5, shift=3 -> all elements -62; acc=70000, scale=1, shift=0 -> 127; acc=-70000 -> -128.
REQ-035 SHALL be covered: m_ready=0 for 5 cycles after the first m_valid -> row 0 data held unchanged, no row skipped.
REQ-036 SHALL be covered: three strobes with m_ready=0 -> first two tiles are drained intact in order, the third is dropped, and overflow_o=1 stays high.
REQ-037 SHALL be covered: count==2, the cycle row 7 loads coincides with a new strobe -> the new tile is accepted, overflow_o stays 0, and 3 tiles are output.
REQ-038 SHALL be covered: rst asserted mid-tile (row 3 pending) -> the next cycle shows m_valid=0, busy_o=0 and overflow_o=0.

Source files
------------

// File: rtl/w4a8_result_drain.sv
// Ping-pong result-tile buffer that requantizes one row per cycle onto a valid/ready stream.
// Two-cycle strobe-to-first-row latency; a third tile arriving while both slots are full is dropped.
module w4a8_result_drain #(
  parameter int M            = 8,
  parameter int N            = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int SCALE_WIDTH  = 16,
  parameter int OUT_WIDTH    = 8,
  localparam int ROW_W       = (M > 1) ? $clog2(M) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tile_valid_i,
  input  logic [M*N*RESULT_WIDTH-1:0]     tile_i,
  input  logic [N*SCALE_WIDTH-1:0]        scale_i,
  input  logic [5:0]                      shift_i,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [N*OUT_WIDTH-1:0]          m_data,
  output logic [ROW_W-1:0]                m_row,
  output logic                            m_last,
  output logic                            overflow_o,
  output logic                            busy_o
);

  localparam int PW = RESULT_WIDTH + SCALE_WIDTH;
  // Wide enough that a rounding bias of up to 2^62 never wraps the product.
  localparam int EW = ((PW > 64) ? PW : 64) + 2;
  localparam logic signed [EW-1:0] OMAX = (EW'(1) << (OUT_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] OMIN = ~OMAX;

  logic [M*N*RESULT_WIDTH-1:0] tile_mem  [2];
  logic [N*SCALE_WIDTH-1:0]    scale_mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  count;
  logic [ROW_W-1:0]            row_cnt;
  logic                        load;
  logic                        free_slot;
  logic                        accept;
  logic [N*OUT_WIDTH-1:0]      row_q;

  assign load      = (count != 2'd0) && (!m_valid || m_ready);
  assign free_slot = load && (row_cnt == ROW_W'(M - 1));
  // A full buffer still accepts when the last row of the read slot leaves this cycle.
  assign accept    = !rst && tile_valid_i && ((count != 2'd2) || free_slot);
  assign busy_o    = (count != 2'd0) || m_valid;

  always_comb begin
    row_q = '0;
    for (int j = 0; j < N; j++) begin
      logic signed [RESULT_WIDTH-1:0] acc;
      logic signed [SCALE_WIDTH-1:0]  sc;
      logic signed [PW-1:0]           prod;
      logic signed [EW-1:0]           ext;
      logic signed [EW-1:0]           bias;
      logic signed [EW-1:0]           rnd;
      int                             base;
      base = (int'(row_cnt) * N + j) * RESULT_WIDTH;
      acc  = $signed(tile_mem[rd_ptr][base +: RESULT_WIDTH]);
      sc   = $signed(scale_mem[rd_ptr][j*SCALE_WIDTH +: SCALE_WIDTH]);
      prod = acc * sc;
      ext  = prod;
      bias = (shift_i == 6'd0) ? '0 : (EW'(1) << (shift_i - 6'd1));
      rnd  = (ext + bias) >>> shift_i;
      if (rnd > OMAX)
        row_q[j*OUT_WIDTH +: OUT_WIDTH] = OMAX[OUT_WIDTH-1:0];
      else if (rnd < OMIN)
        row_q[j*OUT_WIDTH +: OUT_WIDTH] = OMIN[OUT_WIDTH-1:0];
      else
        row_q[j*OUT_WIDTH +: OUT_WIDTH] = rnd[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tile_mem[wr_ptr]  <= tile_i;
      scale_mem[wr_ptr] <= scale_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      row_cnt    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_row      <= '0;
      m_last     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= ~wr_ptr;
      if (tile_valid_i && !accept)
        overflow_o <= 1'b1;
      count <= count + 2'(accept) - 2'(free_slot);
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= row_q;
        m_row   <= row_cnt;
        m_last  <= (row_cnt == ROW_W'(M - 1));
        if (free_slot) begin
          rd_ptr  <= ~rd_ptr;
          row_cnt <= '0;
        end else begin
          row_cnt <= row_cnt + ROW_W'(1);
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_w4a8_result_drain.sv
// Directed bench for w4a8_result_drain: latency, requantization, backpressure, overflow, reset.
module tb_w4a8_result_drain;
  localparam int M  = 8;
  localparam int N  = 8;
  localparam int RW = 32;
  localparam int SW = 16;
  localparam int OW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tile_valid_i;
  logic [M*N*RW-1:0]    tile_i;
  logic [N*SW-1:0]      scale_i;
  logic [5:0]           shift_i;
  logic                 m_valid;
  logic                 m_ready;
  logic [N*OW-1:0]      m_data;
  logic [2:0]           m_row;
  logic                 m_last;
  logic                 overflow_o;
  logic                 busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  w4a8_result_drain #(.M(M), .N(N), .RESULT_WIDTH(RW), .SCALE_WIDTH(SW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .tile_valid_i(tile_valid_i), .tile_i(tile_i), .scale_i(scale_i),
    .shift_i(shift_i), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  // Element (i,j) = base + i*step.
  function automatic logic [M*N*RW-1:0] mk_tile(int base, int step);
    logic [M*N*RW-1:0] t;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        t[(i*N+j)*RW +: RW] = RW'(base + i*step);
    return t;
  endfunction

  function automatic logic [N*SW-1:0] mk_scale(int s, int colstep);
    logic [N*SW-1:0] v;
    for (int j = 0; j < N; j++) v[j*SW +: SW] = SW'(s + j*colstep);
    return v;
  endfunction

  // Column j = v * (1 + j*colmul).
  function automatic logic [N*OW-1:0] mk_row(int v, int colmul);
    logic [N*OW-1:0] r;
    for (int j = 0; j < N; j++) r[j*OW +: OW] = OW'(v * (1 + j*colmul));
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tile_valid_i = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tile_valid_i = 1'b1; m_ready = 1'b0;
    tile_i = mk_tile(1, 0); scale_i = mk_scale(1, 0); shift_i = 6'd0;
    tick(); tick();
    checks++;
    if ({m_valid, m_last, m_row, overflow_o, busy_o} !== 7'b0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_state: got v=%b l=%b r=%0d ovf=%b busy=%b d=%h, want all zero",
               m_valid, m_last, m_row, overflow_o, busy_o, m_data);
    end
    rst = 1'b0; tile_valid_i = 1'b0;
    tick(); tick();
    checks++;
    if (m_valid !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignores_strobe: got v=%b busy=%b, want 0 0", m_valid, busy_o);
    end
  endtask

  task automatic test_basic();
    m_ready = 1'b1; shift_i = 6'd3;
    tile_i = mk_tile(100, 0); scale_i = mk_scale(5, 0); tile_valid_i = 1'b1;
    tick(); tile_valid_i = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++; $display("FAIL basic_c1_valid: got %b want 0", m_valid);
    end
    for (int r = 0; r < M; r++) begin
      tick();
      checks++;
      if ({m_valid, m_last, m_row} !== {1'b1, (r == M-1), 3'(r)}) begin
        failures++;
        $display("FAIL basic_row%0d_ctrl: got v=%b l=%b r=%0d want v=1 l=%b r=%0d",
                 r, m_valid, m_last, m_row, (r == M-1), r);
      end
      checks++;
      if (m_data !== mk_row(63, 0)) begin
        failures++; $display("FAIL basic_row%0d_data: got %h want %h", r, m_data, mk_row(63, 0));
      end
    end
    tick();
    checks++;
    if (m_valid !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL basic_idle: got v=%b busy=%b want 0 0", m_valid, busy_o);
    end
  endtask

  task automatic test_requant_case(string name, int acc, int sc, int colstep, int sh,
                                   int expv, int colmul);
    int budget;
    m_ready = 1'b1; shift_i = 6'(sh);
    tile_i = mk_tile(acc, 0); scale_i = mk_scale(sc, colstep); tile_valid_i = 1'b1;
    tick(); tile_valid_i = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== mk_row(expv, colmul)) begin
      failures++;
      $display("FAIL requant_%s: got v=%b d=%h want v=1 d=%h", name, m_valid, m_data,
               mk_row(expv, colmul));
    end
    budget = 0;
    while (busy_o === 1'b1 && budget < 20) begin
      tick(); budget++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL requant_%s_drain: busy=%b after %0d cycles, want 0", name, busy_o, budget);
    end
  endtask

  task automatic test_requant();
    test_requant_case("neg_round", -100, 5, 0, 3, -62, 0);
    test_requant_case("sat_pos", 70000, 1, 0, 0, 127, 0);
    test_requant_case("sat_neg", -70000, 1, 0, 0, -128, 0);
    test_requant_case("half_up_pos", 3, 1, 0, 1, 2, 0);
    test_requant_case("half_up_neg", -3, 1, 0, 1, -1, 0);
    test_requant_case("col_scale", 3, 1, 1, 0, 3, 1);
    test_requant_case("big_shift", 100000, 1000, 0, 20, 95, 0);
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0; shift_i = 6'd0;
    tile_i = mk_tile(10, 1); scale_i = mk_scale(1, 0); tile_valid_i = 1'b1;
    tick(); tile_valid_i = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_row !== 3'd0 || m_data !== mk_row(10, 0)) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b r=%0d d=%h want v=1 r=0 d=%h",
                 k, m_valid, m_row, m_data, mk_row(10, 0));
      end
      tick();
    end
    for (int r = 0; r < M; r++) begin
      checks++;
      if (m_valid !== 1'b1 || m_row !== 3'(r) || m_data !== mk_row(10 + r, 0)) begin
        failures++;
        $display("FAIL bp_row%0d: got v=%b r=%0d d=%h want v=1 r=%0d d=%h",
                 r, m_valid, m_row, m_data, r, mk_row(10 + r, 0));
      end
      m_ready = 1'b1;
      tick();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++; $display("FAIL bp_end: got v=%b want 0", m_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    m_ready = 1'b0; shift_i = 6'd0; scale_i = mk_scale(1, 0);
    tile_i = mk_tile(20, 1); tile_valid_i = 1'b1; tick();
    tile_i = mk_tile(40, 1); tick();
    tile_i = mk_tile(90, 1); tick();
    tile_valid_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1) begin
      failures++; $display("FAIL ovf_set: got %b want 1", overflow_o);
    end
    for (int n = 0; n < 2*M; n++) begin
      checks++;
      if (m_valid !== 1'b1 || m_row !== 3'(n % M) ||
          m_data !== mk_row(((n < M) ? 20 : 40) + n % M, 0)) begin
        failures++;
        $display("FAIL ovf_row%0d: got v=%b r=%0d d=%h want v=1 r=%0d d=%h", n, m_valid, m_row,
                 m_data, n % M, mk_row(((n < M) ? 20 : 40) + n % M, 0));
      end
      m_ready = 1'b1;
      tick();
    end
    checks++;
    if (m_valid !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_end: got v=%b busy=%b ovf=%b want 0 0 1", m_valid, busy_o, overflow_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bases[3];
    bases[0] = 5; bases[1] = 30; bases[2] = 60;
    do_reset();
    m_ready = 1'b1; shift_i = 6'd0; scale_i = mk_scale(1, 0);
    n = 0;
    for (int idx = 0; idx < 30; idx++) begin
      tile_valid_i = (idx == 0 || idx == 1 || idx == 8);
      tile_i = mk_tile(bases[(idx == 0) ? 0 : (idx == 1) ? 1 : 2], 1);
      if (m_valid === 1'b1) begin
        if (n < 3*M) begin
          checks++;
          if (m_row !== 3'(n % M) || m_data !== mk_row(bases[n / M] + n % M, 0)) begin
            failures++;
            $display("FAIL b2b_row%0d: got r=%0d d=%h want r=%0d d=%h", n, m_row, m_data,
                     n % M, mk_row(bases[n / M] + n % M, 0));
          end
        end
        n++;
      end
      tick();
    end
    tile_valid_i = 1'b0;
    checks++;
    if (n !== 3*M || overflow_o !== 1'b0) begin
      failures++; $display("FAIL b2b_count: got rows=%0d ovf=%b want rows=%0d ovf=0", n, overflow_o, 3*M);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0; shift_i = 6'd0; scale_i = mk_scale(1, 0);
    tile_i = mk_tile(20, 1); tile_valid_i = 1'b1; tick();
    tile_i = mk_tile(40, 1); tick();
    tile_i = mk_tile(90, 1); tick();
    tile_valid_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      m_ready = 1'b1; tick();
    end
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_row !== 3'd3 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: got v=%b r=%0d ovf=%b want v=1 r=3 ovf=1", m_valid, m_row, overflow_o);
    end
    rst = 1'b1; tick();
    checks++;
    if (m_valid !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear: got v=%b busy=%b ovf=%b want 0 0 0", m_valid, busy_o, overflow_o);
    end
    rst = 1'b0; m_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (m_valid !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_leftover: got v=%b busy=%b want 0 0", m_valid, busy_o);
    end
    tile_i = mk_tile(50, 1); tile_valid_i = 1'b1; tick();
    tile_valid_i = 1'b0; tick();
    checks++;
    if (m_valid !== 1'b1 || m_row !== 3'd0 || m_data !== mk_row(50, 0)) begin
      failures++;
      $display("FAIL rstmid_new_tile: got v=%b r=%0d d=%h want v=1 r=0 d=%h",
               m_valid, m_row, m_data, mk_row(50, 0));
    end
  endtask

  initial begin
    rst = 1'b1; tile_valid_i = 1'b0; m_ready = 1'b0;
    tile_i = '0; scale_i = '0; shift_i = 6'd0;
    tick();
    test_reset();
    test_basic();
    test_requant();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
